imm_ext_stage: RTL and testbench
================================

# imm_ext_stage

Registered, handshaked immediate-generation stage for the decode path. Accepts a raw instruction plus an `imm_type` selector and returns the XLEN-wide immediate one cycle later. Covers all base formats (I, S, B, U, J) and optionally the CSR zimm format. A two-entry skid buffer decouples decode from a stalling execute stage, and a flush input squashes in-flight entries on redirect.

## Interface
Parameters:
- `XLEN`, 32. Immediate width; legal values are 32 and 64.
- `TAG_W`, 32. Width of the opaque sideband tag (typically the PC), carried alongside each entry.

Ports:
- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `flush`  in  1  Synchronous squash of all held entries.
- `in_valid`  in  1  Upstream entry valid.
- `in_ready`  out  1  Stage can accept an entry this cycle.
- `in_instr`  in  32  Raw instruction word.
- `in_imm_src`  in  3  Immediate type (`imm_type`).
- `in_tag`  in  TAG_W  Sideband, passed through unchanged.
- `out_valid`  out  1  Output entry valid.
- `out_ready`  in  1  Downstream accepts the entry.
- `out_imm`  out  XLEN  Extended immediate.
- `out_tag`  out  TAG_W  Tag of the output entry.
- `out_illegal`  out  1  Selector code unsupported; `out_imm` = 0.

## Operation
- Extraction, with all formats sign-extended from `instr[31]` to XLEN:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`.
  - U: `{instr[31:12], 12'b0}`, sign-extended to 64 when XLEN = 64.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`.
  - Z: `instr[19:15]`, zero-extended.
- Codes: I=0, S=1, B=2, U=3, J=4, Z=5. Codes 6 and 7 always yield `out_illegal`=1 and `out_imm`=0.
- Storage: an output register (O) plus a skid register (K), each holding valid, imm, tag and illegal. Extraction happens before storage, so K holds computed results.
- Handshake: fire_in = `in_valid & in_ready`; fire_out = `out_valid & out_ready`.
  - `in_ready` = !K.valid, driven directly from a register with no combinational path from `out_ready`.
  - O loads when `!O.valid | out_ready`. The source is K if K.valid, otherwise the input on fire_in.
  - K loads on fire_in when O is valid and not draining.
  - When K drains into O and fire_in happens in the same cycle, the input goes to K. This case cannot occur because `in_ready`=0 whenever K is valid.
- States, implicit from {O.valid, K.valid}:
  - EMPTY {0,0} goes to ONE on fire_in.
  - ONE {1,0} goes to FULL on fire_in without fire_out. It goes to EMPTY on fire_out without fire_in. It stays ONE when both fire.
  - FULL {1,1} goes to ONE on fire_out.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Flush: clears O.valid and K.valid next edge and overrides a same-cycle fire_in (that entry is discarded). A same-cycle fire_out is still a legal consumption.

## Timing
- Latency 1 cycle from fire_in to `out_valid` when the stage is empty.
- Full throughput: 1 entry per cycle with `out_ready` held high.
- Reset values: `out_valid`=0, `out_imm`=0, `out_tag`=0, `out_illegal`=0, `in_ready`=1. K.valid=0.
- Reset asserted mid-operation: all entries are lost immediately (asynchronous). `in_ready` is 1 throughout reset.
- Data registers hold their value when not loading. `out_imm`/`out_tag` must stay stable while `out_valid & !out_ready`.

## Configuration
- `IMM_ZICSR_EN` defined: code 5 (Z) is supported.
- `IMM_ZICSR_EN` undefined: code 5 is treated as illegal, like 6 and 7, and no zimm logic is synthesised.

## Structure
- `common.vh` holds the `imm_type` enum, widened to 3 bits (`IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_Z`). This replaces the 3-entry usage.
- Sub-module `imm_ext_comb` is pure combinational extraction (XLEN-parameterised, `IMM_ZICSR_EN`-aware) producing imm and illegal. `imm_ext_stage` instantiates it once, on the input side.

## Test plan
- I/S/B/J, XLEN = 32, `out_ready`=1. Expected `out_imm` one cycle after fire:
  - `0xFFF00093`/I gives `0xFFFFFFFF`.
  - `0xFE112E23`/S gives `0xFFFFFFFC`.
  - `0xFE000EE3`/B gives `0xFFFFFFFC`.
  - `0x008000EF`/J gives `0x00000008`.
- XLEN = 64, `0x800000B7`/U gives `0xFFFFFFFF80000000`. Z with rs1 field `0x1F` gives `0x000000000000001F` when `IMM_ZICSR_EN` is defined. Without the macro, code 5 gives `out_illegal`=1 and imm 0. Codes 6 and 7 give illegal in both builds.
- Backpressure: hold `out_ready`=0 and send tags A and B back-to-back.
  - `in_ready` drops the cycle after B is accepted.
  - Releasing `out_ready` yields A then B on consecutive cycles.
  - `in_ready` returns to 1 the cycle after A drains.
- Streaming: 100 random entries with random `in_valid`/`out_ready`. Outputs match a reference queue in order, and `out_*` stay stable during any stall.
- Flush: flush with the stage FULL while `in_valid`=1. Next cycle `out_valid`=0, K empty and `in_ready`=1, and the flushed-cycle input never appears at the output.
- Reset: drop `rst_n` asynchronously mid-cycle while FULL. `out_valid`=0 and `in_ready`=1 without waiting for a clock edge, and all outputs read zero.

Source files
------------

// File: rtl/imm_ext_stage_pkg.sv
// Shared types for the immediate-generation stage: selector codes and skid-buffer state.
// Build option: define IMM_ZICSR_EN to enable the CSR zimm (code 5) format.
package imm_ext_stage_pkg;

  localparam int IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_type_e;

  // Encoding is {O.valid, K.valid}, so the valid flags are plain state bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Pure combinational immediate extraction for I/S/B/U/J, plus zimm when IMM_ZICSR_EN is defined.
// Unsupported selector codes flag illegal and return zero.
module imm_ext_comb
  import imm_ext_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = &{1'b0, instr[6:0]};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm = XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
`ifdef IMM_ZICSR_EN
      IMM_Z: imm = XLEN'(instr[19:15]);
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered, handshaked immediate stage: extraction on the input side, then an output
// register backed by a one-entry skid register. Honours IMM_ZICSR_EN via imm_ext_comb.
module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal
);

  stage_state_e state, state_d;

  logic            o_valid, k_valid;
  logic [XLEN-1:0] o_imm, k_imm, ext_imm;
  logic [TAG_W-1:0] o_tag, k_tag;
  logic            o_ill, k_ill, ext_ill;
  logic            fire_in, fire_out, o_load, k_load;

  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (ext_imm),
    .illegal (ext_ill)
  );

  assign fire_in  = in_valid & in_ready;
  assign fire_out = o_valid & out_ready;
  // O refills whenever it is free or draining, preferring the older skid entry.
  assign o_load   = !flush & (!o_valid | out_ready) & (k_valid | fire_in);
  assign k_load   = !flush & fire_in & o_valid & !out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (fire_in) state_d = ST_ONE;
        ST_ONE: begin
          if (fire_in && !fire_out)      state_d = ST_FULL;
          else if (fire_out && !fire_in) state_d = ST_EMPTY;
        end
        ST_FULL:  if (fire_out) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready comes straight from the K.valid state bit, never from out_ready.
  always_comb begin
    o_valid   = state[1];
    k_valid   = state[0];
    in_ready  = !k_valid;
    out_valid = o_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_imm <= '0;
      o_tag <= '0;
      o_ill <= 1'b0;
      k_imm <= '0;
      k_tag <= '0;
      k_ill <= 1'b0;
    end else begin
      if (o_load) begin
        o_imm <= k_valid ? k_imm : ext_imm;
        o_tag <= k_valid ? k_tag : in_tag;
        o_ill <= k_valid ? k_ill : ext_ill;
      end
      if (k_load) begin
        k_imm <= ext_imm;
        k_tag <= in_tag;
        k_ill <= ext_ill;
      end
    end
  end

  assign out_imm     = o_imm;
  assign out_tag     = o_tag;
  assign out_illegal = o_ill;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: one XLEN=32 and one XLEN=64 instance driven in parallel.
// Zimm expectations follow IMM_ZICSR_EN.
module tb_imm_ext_stage;
  import imm_ext_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_imm_src;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_ill32)
  );

  imm_ext_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_ill64)
  );

  task automatic test_reset;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32 got %b want 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready32 got %b want 1", in_ready32); end
    checks++; if (out_imm32 !== 32'h0) begin errors++; $display("FAIL reset_out_imm32 got %h want 0", out_imm32); end
    checks++; if (out_tag32 !== 32'h0) begin errors++; $display("FAIL reset_out_tag32 got %h want 0", out_tag32); end
    checks++; if (out_ill32 !== 1'b0) begin errors++; $display("FAIL reset_out_illegal32 got %b want 0", out_ill32); end
    checks++; if (out_valid64 !== 1'b0) begin errors++; $display("FAIL reset_out_valid64 got %b want 0", out_valid64); end
    checks++; if (in_ready64 !== 1'b1) begin errors++; $display("FAIL reset_in_ready64 got %b want 1", in_ready64); end
    checks++; if (out_imm64 !== 64'h0) begin errors++; $display("FAIL reset_out_imm64 got %h want 0", out_imm64); end
  endtask

  // Vectors are issued back to back with out_ready high, so this also covers full throughput.
  task automatic test_formats;
    logic [31:0] v_instr [10];
    logic [2:0]  v_src   [10];
    logic [31:0] e32     [10];
    logic [63:0] e64     [10];
    logic        e_ill   [10];
    v_instr[0] = 32'hFFF00093; v_src[0] = 3'd0; e32[0] = 32'hFFFFFFFF; e64[0] = 64'hFFFFFFFFFFFFFFFF; e_ill[0] = 1'b0;
    v_instr[1] = 32'hFE112E23; v_src[1] = 3'd1; e32[1] = 32'hFFFFFFFC; e64[1] = 64'hFFFFFFFFFFFFFFFC; e_ill[1] = 1'b0;
    v_instr[2] = 32'hFE000EE3; v_src[2] = 3'd2; e32[2] = 32'hFFFFFFFC; e64[2] = 64'hFFFFFFFFFFFFFFFC; e_ill[2] = 1'b0;
    v_instr[3] = 32'h008000EF; v_src[3] = 3'd4; e32[3] = 32'h00000008; e64[3] = 64'h0000000000000008; e_ill[3] = 1'b0;
    v_instr[4] = 32'h800000B7; v_src[4] = 3'd3; e32[4] = 32'h80000000; e64[4] = 64'hFFFFFFFF80000000; e_ill[4] = 1'b0;
    v_instr[5] = 32'h12345037; v_src[5] = 3'd3; e32[5] = 32'h12345000; e64[5] = 64'h0000000012345000; e_ill[5] = 1'b0;
    v_instr[6] = 32'h7FF00093; v_src[6] = 3'd0; e32[6] = 32'h000007FF; e64[6] = 64'h00000000000007FF; e_ill[6] = 1'b0;
`ifdef IMM_ZICSR_EN
    v_instr[7] = 32'hFFFF8073; v_src[7] = 3'd5; e32[7] = 32'h0000001F; e64[7] = 64'h000000000000001F; e_ill[7] = 1'b0;
`else
    v_instr[7] = 32'hFFFF8073; v_src[7] = 3'd5; e32[7] = 32'h00000000; e64[7] = 64'h0000000000000000; e_ill[7] = 1'b1;
`endif
    v_instr[8] = 32'hFFFFFFFF; v_src[8] = 3'd6; e32[8] = 32'h00000000; e64[8] = 64'h0000000000000000; e_ill[8] = 1'b1;
    v_instr[9] = 32'hFFFFFFFF; v_src[9] = 3'd7; e32[9] = 32'h00000000; e64[9] = 64'h0000000000000000; e_ill[9] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'b1;
      in_instr   = v_instr[i];
      in_imm_src = v_src[i];
      in_tag     = 32'h100 + 32'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid got %b want 1", i, out_valid32); end
      checks++; if (out_imm32 !== e32[i]) begin errors++; $display("FAIL fmt%0d_imm32 got %h want %h", i, out_imm32, e32[i]); end
      checks++; if (out_ill32 !== e_ill[i]) begin errors++; $display("FAIL fmt%0d_illegal32 got %b want %b", i, out_ill32, e_ill[i]); end
      checks++; if (out_imm64 !== e64[i]) begin errors++; $display("FAIL fmt%0d_imm64 got %h want %h", i, out_imm64, e64[i]); end
      checks++; if (out_ill64 !== e_ill[i]) begin errors++; $display("FAIL fmt%0d_illegal64 got %b want %b", i, out_ill64, e_ill[i]); end
      checks++; if (out_tag32 !== 32'h100 + 32'(i)) begin errors++; $display("FAIL fmt%0d_tag got %h want %h", i, out_tag32, 32'h100 + 32'(i)); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL fmt_drain_valid got %b want 0", out_valid32); end
  endtask

  task automatic test_backpressure;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_imm_src = 3'd0;
    in_instr   = 32'h00100093;
    in_tag     = 32'hAAAA0001;
    @(posedge clk); #1;
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got %b want 1", in_ready32); end
    in_instr = 32'h00200093;
    in_tag   = 32'hBBBB0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got %b want 0", in_ready32); end
    checks++; if (out_tag32 !== 32'hAAAA0001) begin errors++; $display("FAIL bp_head_tag got %h want aaaa0001", out_tag32); end
    @(posedge clk); #1;
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got %b want 1", out_valid32); end
    checks++; if (out_tag32 !== 32'hAAAA0001) begin errors++; $display("FAIL bp_stall_tag got %h want aaaa0001", out_tag32); end
    checks++; if (out_imm32 !== 32'h1) begin errors++; $display("FAIL bp_stall_imm got %h want 1", out_imm32); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL bp_b_valid got %b want 1", out_valid32); end
    checks++; if (out_tag32 !== 32'hBBBB0002) begin errors++; $display("FAIL bp_b_tag got %h want bbbb0002", out_tag32); end
    checks++; if (out_imm32 !== 32'h2) begin errors++; $display("FAIL bp_b_imm got %h want 2", out_imm32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL bp_ready_after_drain got %b want 1", in_ready32); end
    @(posedge clk); #1;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got %b want 0", out_valid32); end
  endtask

  task automatic test_stream;
    logic [31:0] q_tag[$];
    logic [31:0] q_imm[$];
    logic [31:0] h_tag, h_imm, exp_imm;
    logic        stall, fi, fo;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stall = 1'b0; h_tag = '0; h_imm = '0;
    while (got < 100 && cyc < 3000) begin
      if (stall) begin
        checks++; if (out_valid32 !== 1'b1 || out_tag32 !== h_tag || out_imm32 !== h_imm) begin
          errors++; $display("FAIL stream_stall_stable got %b/%h/%h want 1/%h/%h", out_valid32, out_tag32, out_imm32, h_tag, h_imm);
        end
      end
      in_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_instr   = $urandom;
      in_imm_src = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd0;
      in_tag     = 32'h5000 + 32'(sent);
      out_ready  = ($urandom_range(0, 2) != 0);
      #2;
      fi = in_valid & in_ready32;
      fo = out_valid32 & out_ready;
      if (fo) begin
        if (q_tag.size() == 0) begin
          checks++; errors++; $display("FAIL stream_unexpected got tag %h want none", out_tag32);
        end else begin
          checks++; if (out_tag32 !== q_tag[0]) begin errors++; $display("FAIL stream_tag got %h want %h", out_tag32, q_tag[0]); end
          checks++; if (out_imm32 !== q_imm[0]) begin errors++; $display("FAIL stream_imm got %h want %h", out_imm32, q_imm[0]); end
          void'(q_tag.pop_front());
          void'(q_imm.pop_front());
        end
        got++;
      end
      if (fi) begin
        if (in_imm_src == 3'd3) exp_imm = {in_instr[31:12], 12'h000};
        else                    exp_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        q_tag.push_back(in_tag);
        q_imm.push_back(exp_imm);
        sent++;
      end
      stall = out_valid32 & !out_ready;
      h_tag = out_tag32;
      h_imm = out_imm32;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got != 100) begin errors++; $display("FAIL stream_timeout got %0d want 100", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_imm_src = 3'd0;
    in_instr   = 32'h00300093;
    in_tag     = 32'hF0000001;
    @(posedge clk); #1;
    in_tag = 32'hF0000002;
    @(posedge clk); #1;
    checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b want 0", in_ready32); end
    in_tag = 32'hF0000003;
    flush  = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready32); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d got valid %b tag %h want 0", i, out_valid32, out_tag32); end
    end
  endtask

  task automatic test_async_reset;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_imm_src = 3'd0;
    in_instr   = 32'hFFF00093;
    in_tag     = 32'hC0000001;
    @(posedge clk); #1;
    in_tag = 32'hC0000002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin errors++; $display("FAIL arst_prefill got %b/%b want 1/0", out_valid32, in_ready32); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b want 1", in_ready32); end
    checks++; if (out_imm32 !== 32'h0 || out_tag32 !== 32'h0 || out_ill32 !== 1'b0) begin
      errors++; $display("FAIL arst_data32 got %h/%h/%b want 0/0/0", out_imm32, out_tag32, out_ill32);
    end
    checks++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_imm64 !== 64'h0) begin
      errors++; $display("FAIL arst_dut64 got %b/%b/%h want 0/1/0", out_valid64, in_ready64, out_imm64);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL arst_post_valid got %b want 0", out_valid32); end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_instr   = '0;
    in_imm_src = '0;
    in_tag     = '0;
    #2;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_formats;
    test_backpressure;
    test_stream;
    test_flush;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
